wbcarbiter: RTL and testbench
=============================

# wbcarbiter

Round-robin Wishbone classic arbiter that merges NM bus masters (CPU, DMA, debug bridge) onto the single master port of the address-decoding router. One master owns the bus per granted cycle, and ownership lasts for its whole `cyc` assertion. Slave responses are steered back only to the owner. An optional watchdog ends stalled cycles with an error.

## Interface
Parameters:
- `NM`, 2: number of upstream masters (2..8).
- `AW`, 32: address width.
- `DW`, 32: data width.
- `SW`, DW/8: byte-select width.
- `TIMEOUT_CYCLES`, 255: watchdog limit in cycles. Used only with `WBCARBITER_TIMEOUT_EN`.

Ports:
- `i_clk`, in, 1: single clock; all state updates on the rising edge.
- `i_reset`, in, 1: reset, synchronous and active-high.
- `i_mcyc`, `i_mstb`, `i_mwe`, in, NM each: per-master cycle, strobe and write enable.
- `i_maddr`, in, NM*AW: per-master address; master n occupies bits [n*AW +: AW].
- `i_mdata`, in, NM*DW: per-master write data.
- `i_msel`, in, NM*SW: per-master byte selects.
- `o_mack`, `o_merr`, out, NM each: per-master acknowledge and error.
- `o_mdata`, out, NM*DW: per-master read data. Zero for any master that is not the owner.
- `o_scyc`, `o_sstb`, `o_swe`, out, 1 each: to router `i_mcyc`, `i_mstb`, `i_mwe`.
- `o_saddr`, out, AW: to router `i_maddr`.
- `o_sdata`, out, DW: to router `i_mdata`.
- `o_ssel`, out, SW: to router `i_msel`.
- `i_sack`, `i_serr`, in, 1 each: from router `o_mack`, `o_merr`.
- `i_sdata`, in, DW: from router `o_mdata`.

## Operation
- State is one bit, `granted`, plus a `grant` index (clog2(NM) bits) and a `last` index.
- `last` records the most recent owner. Reset sets it to NM-1, so master 0 wins first.
- IDLE (`granted`=0):
  - All slave-side outputs are 0. All `o_mack`, `o_merr` and `o_mdata` are 0.
  - If any `i_mcyc` bit is set, select the first requester searching last+1, last+2, … modulo NM.
  - At the next edge, load `grant` and `last` with that index and set `granted`=1.
- GRANTED:
  - Slave outputs are a combinational mux of master `grant`: `o_scyc`=i_mcyc[grant], `o_sstb`=i_mstb[grant], and likewise for we, addr, data and sel.
  - `o_mack[grant]`=`i_sack`, `o_merr[grant]`=`i_serr`, and master `grant`'s `o_mdata` slice = `i_sdata`. All other masters see 0.
  - When i_mcyc[grant]=0, return to IDLE at the next edge. While in that cycle, `o_scyc` is already 0 because it follows the mux.
- Non-owner masters asserting `stb` receive no ack; they stall.
- The owner may issue any number of back-to-back strobes while it holds `cyc`. Re-arbitration happens only when `cyc` drops.
- A master that drops and immediately re-raises `cyc` takes part in the next arbitration. It loses to any other requester, because it is now `last`.

## Timing
- Grant latency: `cyc` seen in IDLE at cycle t → `o_scyc` high in cycle t+1. There are no grant-to-slave register stages.
- Response path: `i_sack`, `i_serr` and `i_sdata` reach the owner combinationally, with zero latency.
- Turnaround: at least one IDLE cycle between consecutive ownerships.
- Reset:
  - The edge with `i_reset`=1 forces `granted`=0 and `last`=NM-1, and clears the watchdog.
  - From the following cycle all outputs are 0. This holds even mid-transfer; any in-flight ack is dropped.
- Reset has priority over every other transition.

## Configuration
- `WBCARBITER_TIMEOUT_EN` defined:
  - A counter of clog2(TIMEOUT_CYCLES+1) bits increments each GRANTED cycle with `o_sstb`=1 and `i_sack`=`i_serr`=0.
  - The counter clears on ack, on err, on `stb`=0, and in IDLE.
  - On the cycle the count equals TIMEOUT_CYCLES:
    - `o_merr[grant]`=1 for one cycle.
    - `o_scyc` and `o_sstb` are forced to 0.
    - The arbiter goes to IDLE at the next edge, even if the owner still holds `cyc`.
- Undefined: no counter logic; a stalled slave holds the bus indefinitely.

## Test plan
- After reset, masters 0 and 1 raise `cyc`+`stb` together in cycle 0 → master 0 is granted. `o_scyc`=1 and `o_saddr`=master 0's address in cycle 1. Master 1 gets no ack until master 0 drops `cyc`; then master 1 owns the bus 2 cycles later.
- Master 0 reads address 0x1000 and the slave acks with data 0xDEADBEEF → `o_mack`=2'b01. Master 0's data slice = 0xDEADBEEF. Master 1's slice = 0.
- Masters 0 and 1 both request continuously with 3-strobe bursts → ownership alternates 0,1,0,1. No master is granted twice in a row.
- `i_reset` is asserted while master 1 is mid-burst with `i_sack`=1 → the next cycle shows all outputs 0, and master 0 wins the next simultaneous request.
- With `WBCARBITER_TIMEOUT_EN` and TIMEOUT_CYCLES=8, the slave never acks → `o_merr[grant]` pulses exactly 8 cycles after `stb` rises, `o_scyc`=0 in that cycle, and the arbiter is in IDLE after it.
- Without the macro and the same stimulus → `o_scyc` stays high for 1000 cycles and `o_merr`=0.

Source files
------------

// File: rtl/wbcarbiter.sv
// Round-robin Wishbone classic arbiter: merges NM masters onto one router master port.
// Latency: grant one cycle after cyc is seen idle; slave response returns to the owner combinationally.
// Backpressure: non-owner strobes are stalled (no ack) until the owner drops cyc.
//
// Ports: i_clk/i_reset (sync, active-high); per-master i_mcyc/i_mstb/i_mwe/i_maddr/i_mdata/i_msel
// in, o_mack/o_merr/o_mdata out (master n at slice n); o_s* drive the router, i_sack/i_serr/i_sdata
// return from it.
// Build option: define WBCARBITER_TIMEOUT_EN to add a watchdog that errors out a stalled strobe
// after TIMEOUT_CYCLES cycles and releases the bus.
module wbcarbiter #(
   parameter int NM             = 2,
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int SW             = DW/8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [NM-1:0]    i_mcyc,
   input  logic [NM-1:0]    i_mstb,
   input  logic [NM-1:0]    i_mwe,
   input  logic [NM*AW-1:0] i_maddr,
   input  logic [NM*DW-1:0] i_mdata,
   input  logic [NM*SW-1:0] i_msel,
   output logic [NM-1:0]    o_mack,
   output logic [NM-1:0]    o_merr,
   output logic [NM*DW-1:0] o_mdata,
   output logic             o_scyc,
   output logic             o_sstb,
   output logic             o_swe,
   output logic [AW-1:0]    o_saddr,
   output logic [DW-1:0]    o_sdata,
   output logic [SW-1:0]    o_ssel,
   input  logic             i_sack,
   input  logic             i_serr,
   input  logic [DW-1:0]    i_sdata
);

   localparam int GW = (NM > 1) ? $clog2(NM) : 1;

   typedef enum logic {S_IDLE = 1'b0, S_GRANTED = 1'b1} state_t;

   state_t        state, state_nxt;
   logic [GW-1:0] grant, grant_nxt;
   logic [GW-1:0] last, last_nxt;
   logic [GW-1:0] pick, idx;
   logic          pick_vld;

   logic          sel_cyc, sel_stb, sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_data;
   logic [SW-1:0] sel_sel;
   logic          tmo;

   // First requester after the previous owner, wrapping modulo NM; the previous
   // owner itself is examined last, so it only wins when nobody else is asking.
   always_comb begin
      pick     = last;
      pick_vld = 1'b0;
      idx      = last;
      for (int k = 1; k <= NM; k++) begin
         idx = GW'((int'(last) + k) % NM);
         if (!pick_vld && i_mcyc[idx]) begin
            pick     = idx;
            pick_vld = 1'b1;
         end
      end
   end

   // Owner's request lines.
   always_comb begin
      sel_cyc  = 1'b0;
      sel_stb  = 1'b0;
      sel_we   = 1'b0;
      sel_addr = '0;
      sel_data = '0;
      sel_sel  = '0;
      for (int n = 0; n < NM; n++) begin
         if (GW'(n) == grant) begin
            sel_cyc  = i_mcyc[n];
            sel_stb  = i_mstb[n];
            sel_we   = i_mwe[n];
            sel_addr = i_maddr[n*AW +: AW];
            sel_data = i_mdata[n*DW +: DW];
            sel_sel  = i_msel[n*SW +: SW];
         end
      end
   end

`ifdef WBCARBITER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] wd_cnt;

   assign tmo = (state == S_GRANTED) && (wd_cnt == CW'(TIMEOUT_CYCLES));

   // Counts consecutive unanswered strobe cycles of the current owner.
   always_ff @(posedge i_clk) begin
      if (i_reset || state == S_IDLE || tmo || !sel_stb || i_sack || i_serr) begin
         wd_cnt <= '0;
      end else begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end
`else
   // No watchdog in this build: the limit is accepted but has no effect.
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign tmo = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= S_IDLE;
         grant <= '0;
         last  <= GW'(NM - 1);
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         last  <= last_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      last_nxt  = last;
      o_scyc    = 1'b0;
      o_sstb    = 1'b0;
      o_swe     = 1'b0;
      o_saddr   = '0;
      o_sdata   = '0;
      o_ssel    = '0;
      o_mack    = '0;
      o_merr    = '0;
      o_mdata   = '0;
      case (state)
         S_IDLE: begin
            if (pick_vld) begin
               state_nxt = S_GRANTED;
               grant_nxt = pick;
               last_nxt  = pick;
            end
         end
         S_GRANTED: begin
            // A watchdog expiry withdraws cyc/stb in the same cycle it reports the error.
            o_scyc  = sel_cyc & ~tmo;
            o_sstb  = sel_stb & ~tmo;
            o_swe   = sel_we;
            o_saddr = sel_addr;
            o_sdata = sel_data;
            o_ssel  = sel_sel;
            for (int n = 0; n < NM; n++) begin
               if (GW'(n) == grant) begin
                  o_mack[n]            = i_sack;
                  o_merr[n]            = i_serr | tmo;
                  o_mdata[n*DW +: DW]  = i_sdata;
               end
            end
            if (!sel_cyc || tmo) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_wbcarbiter.sv
`timescale 1ns/1ps
module tb_wbcarbiter;
   localparam int NM = 3;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int TO = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NM-1:0]    i_mcyc, i_mstb, i_mwe;
   logic [NM*AW-1:0] i_maddr;
   logic [NM*DW-1:0] i_mdata;
   logic [NM*SW-1:0] i_msel;
   logic [NM-1:0]    o_mack, o_merr;
   logic [NM*DW-1:0] o_mdata;
   logic             o_scyc, o_sstb, o_swe;
   logic [AW-1:0]    o_saddr;
   logic [DW-1:0]    o_sdata;
   logic [SW-1:0]    o_ssel;
   logic             i_sack, i_serr;
   logic [DW-1:0]    i_sdata;

   always #5 clk = ~clk;

   wbcarbiter #(.NM(NM), .AW(AW), .DW(DW), .SW(SW), .TIMEOUT_CYCLES(TO)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_mcyc(i_mcyc), .i_mstb(i_mstb), .i_mwe(i_mwe),
      .i_maddr(i_maddr), .i_mdata(i_mdata), .i_msel(i_msel),
      .o_mack(o_mack), .o_merr(o_merr), .o_mdata(o_mdata),
      .o_scyc(o_scyc), .o_sstb(o_sstb), .o_swe(o_swe),
      .o_saddr(o_saddr), .o_sdata(o_sdata), .o_ssel(o_ssel),
      .i_sack(i_sack), .i_serr(i_serr), .i_sdata(i_sdata)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: owner index (-1 = bus free), previous owner, stall count.
   int  m_owner = -1;
   int  m_last  = NM - 1;
   int  m_cnt   = 0;
   bit  chk_en  = 1'b0;
   bit  mt, ct, found;

   function automatic bit m_tmo();
`ifdef WBCARBITER_TIMEOUT_EN
      return (m_owner >= 0) && (m_cnt == TO);
`else
      return 1'b0;
`endif
   endfunction

   always @(posedge clk) begin
      mt = m_tmo();
      if (rst) begin
         m_owner = -1;
         m_last  = NM - 1;
         m_cnt   = 0;
         chk_en  = 1'b1;
      end else if (m_owner < 0) begin
         m_cnt = 0;
         found = 1'b0;
         for (int k = 1; k <= NM; k++) begin
            if (!found && i_mcyc[(m_last + k) % NM]) begin
               m_owner = (m_last + k) % NM;
               found   = 1'b1;
            end
         end
         if (found) m_last = m_owner;
      end else begin
         if (!mt && i_mstb[m_owner] && !i_sack && !i_serr) m_cnt++;
         else m_cnt = 0;
         if (mt || !i_mcyc[m_owner]) begin
            m_owner = -1;
            m_cnt   = 0;
         end
      end
   end

   logic             e_cyc, e_stb, e_we;
   logic [AW-1:0]    e_addr;
   logic [DW-1:0]    e_dat;
   logic [SW-1:0]    e_sel;
   logic [NM-1:0]    e_ack, e_err;
   logic [NM*DW-1:0] e_md;

   always @(negedge clk) begin
      if (chk_en) begin
         ct = m_tmo();
         e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
         e_addr = '0; e_dat = '0; e_sel = '0;
         e_ack = '0; e_err = '0; e_md = '0;
         if (m_owner >= 0) begin
            e_cyc  = i_mcyc[m_owner] & ~ct;
            e_stb  = i_mstb[m_owner] & ~ct;
            e_we   = i_mwe[m_owner];
            e_addr = i_maddr[m_owner*AW +: AW];
            e_dat  = i_mdata[m_owner*DW +: DW];
            e_sel  = i_msel[m_owner*SW +: SW];
            e_ack[m_owner]          = i_sack;
            e_err[m_owner]          = i_serr | ct;
            e_md[m_owner*DW +: DW]  = i_sdata;
         end
         check("m_scyc", o_scyc, e_cyc);
         check("m_sstb", o_sstb, e_stb);
         check("m_swe", o_swe, e_we);
         check("m_saddr", o_saddr, e_addr);
         check("m_sdata", o_sdata, e_dat);
         check("m_ssel", o_ssel, e_sel);
         check("m_mack", o_mack, e_ack);
         check("m_merr", o_merr, e_err);
         check("m_mdata", o_mdata, e_md);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_mcyc = '0; i_mstb = '0; i_mwe = '0;
      i_maddr = '0; i_mdata = '0; i_msel = '0;
      i_sack = 1'b0; i_serr = 1'b0; i_sdata = '0;
   endtask

   task automatic set_m(input int n, input bit cyc, input bit stb, input logic [AW-1:0] a);
      i_mcyc[n] = cyc;
      i_mstb[n] = stb;
      i_mwe[n]  = 1'b0;
      i_maddr[n*AW +: AW] = a;
      i_mdata[n*DW +: DW] = {16'h5A5A, a};
      i_msel[n*SW +: SW]  = '1;
   endtask

   logic [AW-1:0] addr_of [NM];

   initial begin
      addr_of[0] = 16'h1000; addr_of[1] = 16'h2000; addr_of[2] = 16'h3000;
      idle_inputs();
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_scyc", o_scyc, 1'b0);
      check("rst_mack", o_mack, '0);
      check("rst_mdata", o_mdata, '0);

      // Simultaneous request: master 0 first, master 1 waits.
      step();
      set_m(0, 1, 1, addr_of[0]);
      set_m(1, 1, 1, addr_of[1]);
      @(negedge clk);
      check("grant_lat_idle", o_scyc, 1'b0);
      step();
      @(negedge clk);
      check("grant_scyc", o_scyc, 1'b1);
      check("grant_addr", o_saddr, addr_of[0]);
      step();
      i_sack = 1'b1; i_sdata = 32'hDEADBEEF;
      @(negedge clk);
      check("rd_ack", o_mack, 3'b001);
      check("rd_data0", o_mdata[31:0], 32'hDEADBEEF);
      check("rd_data1", o_mdata[63:32], 32'h0);
      step();
      i_sack = 1'b0; i_sdata = '0;
      set_m(0, 0, 0, addr_of[0]);
      @(negedge clk);
      check("drop_scyc", o_scyc, 1'b0);
      check("drop_m1_noack", o_mack, 3'b000);
      step();
      @(negedge clk);
      check("turnaround", o_scyc, 1'b0);
      step();
      @(negedge clk);
      check("m1_owner_addr", o_saddr, addr_of[1]);
      check("m1_owner_scyc", o_scyc, 1'b1);
      step();
      set_m(1, 0, 0, addr_of[1]);
      step();

      // Continuous contention with 3-strobe bursts: ownership alternates.
      set_m(0, 1, 1, addr_of[0]);
      set_m(1, 1, 1, addr_of[1]);
      for (int r = 0; r < 4; r++) begin
         step();
         for (int b = 0; b < 3; b++) begin
            i_sack = 1'b1;
            @(negedge clk);
            check("alt_owner", o_saddr, addr_of[r % 2]);
            check("alt_ack", o_mack, 3'(1 << (r % 2)));
            step();
         end
         i_sack = 1'b0;
         set_m(r % 2, 0, 0, addr_of[r % 2]);
         step();
         set_m(r % 2, 1, 1, addr_of[r % 2]);
      end
      idle_inputs();
      step();

      // Reset during master 1's acked burst.
      set_m(1, 1, 1, addr_of[1]);
      step();
      i_sack = 1'b1; i_sdata = 32'hCAFEF00D;
      @(negedge clk);
      check("pre_rst_ack", o_mack, 3'b010);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_m(0, 1, 1, addr_of[0]);
      set_m(2, 1, 1, addr_of[2]);
      @(negedge clk);
      check("post_rst_scyc", o_scyc, 1'b0);
      check("post_rst_mack", o_mack, 3'b000);
      check("post_rst_mdata", o_mdata, '0);
      step();
      @(negedge clk);
      check("post_rst_winner", o_saddr, addr_of[0]);
      idle_inputs();
      step();
      step();

      // Slave never answers.
      set_m(0, 1, 1, addr_of[0]);
      step();
`ifdef WBCARBITER_TIMEOUT_EN
      for (int i = 0; i < TO; i++) begin
         @(negedge clk);
         check("wd_wait", {o_scyc, o_merr}, {1'b1, 3'b000});
         step();
      end
      @(negedge clk);
      check("wd_fire", {o_scyc, o_merr}, {1'b0, 3'b001});
      step();
      @(negedge clk);
      check("wd_idle", {o_scyc, o_merr}, {1'b0, 3'b000});
`else
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         check("stall_hold", {o_scyc, o_merr}, {1'b1, 3'b000});
         step();
      end
`endif
      idle_inputs();
      step();
      step();

      // Randomized traffic checked by the reference model.
      for (int c = 0; c < 3000; c++) begin
         for (int n = 0; n < NM; n++) begin
            if ($urandom_range(0, 5) == 0) i_mcyc[n] = ~i_mcyc[n];
            i_mstb[n] = i_mcyc[n] & 1'($urandom_range(0, 1));
            i_mwe[n]  = 1'($urandom_range(0, 1));
            i_maddr[n*AW +: AW] = AW'($urandom);
            i_mdata[n*DW +: DW] = $urandom;
            i_msel[n*SW +: SW]  = SW'($urandom);
         end
         i_sack  = ($urandom_range(0, 2) == 0);
         i_serr  = ($urandom_range(0, 9) == 0);
         i_sdata = $urandom;
         rst     = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0;
      idle_inputs();
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
